// File: rtl/pwm_audio_ctrl.sv
// pwm_audio_ctrl: bus-mapped packer that feeds 8-bit PCM samples to the
// PWM FIFO from 32-bit words, with CTRL/STATUS, sample count and irq.
// Ports: clk/resetn (sync, active-low); valid_i/ready_o/addr_i/wr_i/
// wdata_i/wstrb_i/rdata_o bus; pcm_o/we_o/fifo_full_i FIFO; irq_o level.
module pwm_audio_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  addr_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] rdata_o,
  output logic [7:0]  pcm_o,
  output logic        we_o,
  input  logic        fifo_full_i,
  output logic        irq_o
);

  typedef enum logic {
    IDLE,
    PUSH
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         idx_q;
  logic [31:0]        data_q;
  logic [3:0]         mask_q;
  logic               enable_q;
  logic               irq_en_q;
  logic               irq_pend_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic [31:0]        rdata_q;

  logic               in_push;
  logic               stall;
  logic               acc;
  logic               wr_data;
  logic               wr_ctrl;
  logic               wr_stat;
  logic               load;
  logic               cur_m;
  logic               adv;
  logic               done;
  logic               abort;
  logic               irq_set;
  logic [31:0]        status;
  logic [31:0]        rd_val;

  assign in_push = (state_q == PUSH);

  // A new DATA word must wait until the current one is fully consumed.
  assign stall   = in_push && (addr_i == 2'd0) && wr_i;
  // ready_o is a single-cycle pulse, so the held request is not re-taken.
  assign acc     = valid_i && !ready_q && !stall;
  assign wr_data = acc && wr_i && (addr_i == 2'd0);
  assign wr_ctrl = acc && wr_i && (addr_i == 2'd1);
  assign wr_stat = acc && wr_i && (addr_i == 2'd2);
  assign load    = wr_data && enable_q && (wstrb_i != 4'd0);

  assign cur_m   = mask_q[idx_q];
  assign we_o    = in_push && cur_m && !fifo_full_i;
  assign pcm_o   = in_push ? data_q[{idx_q, 3'b000} +: 8] : 8'd0;
  assign adv     = in_push && (!cur_m || !fifo_full_i);
  assign done    = adv && (idx_q == 2'd3);
  assign abort   = in_push &&
                   (!enable_q || (wr_ctrl && !wdata_i[0]));
  assign irq_set = done && !abort;

  assign irq_o   = irq_pend_q && irq_en_q;
  assign ready_o = ready_q;
  assign rdata_o = rdata_q;

  always_comb begin
    status = '0;
    status[0] = in_push;
    status[1] = fifo_full_i;
    status[2] = irq_pend_q;
    status[16 +: CNT_W] = cnt_q;
  end

  always_comb begin
    rd_val = '0;
    case (addr_i)
      2'd1:    rd_val = {30'd0, irq_en_q, enable_q};
      2'd2:    rd_val = status;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = PUSH;
      PUSH: if (abort || done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      idx_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_q <= acc;
      rdata_q <= (acc && !wr_i) ? rd_val : 32'd0;
      if (load) begin
        data_q <= wdata_i;
        mask_q <= wstrb_i;
        idx_q  <= '0;
      end else if (in_push && state_d == IDLE) begin
        idx_q  <= '0;
      end else if (adv) begin
        idx_q  <= idx_q + 2'd1;
      end
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, we_o};
      if (wr_ctrl) begin
        enable_q <= wdata_i[0];
        irq_en_q <= wdata_i[1];
      end
      if (irq_set)
        irq_pend_q <= 1'b1;
      else if (wr_stat && wdata_i[2])
        irq_pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_audio_ctrl.sv
// tb_pwm_audio_ctrl: directed bench for pwm_audio_ctrl.
// Counter width reduced to 8 so the wrap case stays short.
module tb_pwm_audio_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  addr_i;
  logic        wr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic [31:0] rdata_o;
  logic [7:0]  pcm_o;
  logic        we_o;
  logic        fifo_full_i;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pq_c[$];
  int pq_d[$];
  int eq_c[$];
  int eq_d[$];

  pwm_audio_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .valid_i(valid_i), .ready_o(ready_o),
    .addr_i(addr_i), .wr_i(wr_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i),
    .rdata_o(rdata_o), .pcm_o(pcm_o),
    .we_o(we_o), .fifo_full_i(fifo_full_i),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_o) begin
      pq_c.push_back(cyc);
      pq_d.push_back(int'(pcm_o));
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the ack cycle.
  task automatic bus(input logic [1:0] a, input logic w,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output int ackc);
    logic got;
    got = 1'b0;
    rd = '0;
    ackc = -1;
    valid_i = 1'b1;
    addr_i = a;
    wr_i = w;
    wdata_i = d;
    wstrb_i = s;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        got = 1'b1;
        rd = rdata_o;
        ackc = cyc;
      end
    end
    valid_i = 1'b0;
    wr_i = 1'b0;
    chk("bus_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic exp_push(input int c, input int d);
    eq_c.push_back(c);
    eq_d.push_back(d);
  endtask

  task automatic cmp_pushes(input string tag);
    int n;
    chk({tag, "_count"}, pq_d.size(), eq_d.size());
    n = (pq_d.size() < eq_d.size()) ? pq_d.size() : eq_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), pq_c[i], eq_c[i]);
      chk($sformatf("%s_pcm%0d", tag, i), pq_d[i], eq_d[i]);
    end
    pq_c.delete();
    pq_d.delete();
    eq_c.delete();
    eq_d.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    int a;
    int a2;
    resetn = 1'b0;
    valid_i = 1'b0;
    addr_i = '0;
    wr_i = 1'b0;
    wdata_i = '0;
    wstrb_i = '0;
    fifo_full_i = 1'b0;
    idle(3);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_pcm", {24'd0, pcm_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    resetn = 1'b1;
    idle(1);
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("rst_status", rd, 32'h0);
    pq_c.delete();
    pq_d.delete();

    // Full word, no back-pressure.
    bus(2'd1, 1'b1, 32'h1, 4'hf, rd, a);
    bus(2'd0, 1'b1, 32'h44332211, 4'hf, rd, a);
    exp_push(a, 'h11);
    exp_push(a + 1, 'h22);
    exp_push(a + 2, 'h33);
    exp_push(a + 3, 'h44);
    idle(6);
    cmp_pushes("w1111");
    chk("irq_masked", {31'd0, irq_o}, 32'd0);
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("status_w1", rd, 32'h0004_0004);
    bus(2'd1, 1'b1, 32'h3, 4'hf, rd, a);
    chk("irq_on", {31'd0, irq_o}, 32'd1);
    bus(2'd1, 1'b0, 0, 0, rd, a);
    chk("ctrl_rd", rd, 32'h3);
    bus(2'd2, 1'b1, 32'h4, 4'hf, rd, a);
    chk("irq_clr", {31'd0, irq_o}, 32'd0);

    // Sparse mask: slots 0 and 2 are skipped but still cost a cycle.
    bus(2'd0, 1'b1, 32'hAABBCCDD, 4'b1010, rd, a);
    exp_push(a + 1, 'hCC);
    exp_push(a + 3, 'hAA);
    repeat (4) @(negedge clk);
    chk("w1010_irq_a3", {31'd0, irq_o}, 32'd0);
    @(negedge clk);
    chk("w1010_irq_a4", {31'd0, irq_o}, 32'd1);
    idle(2);
    cmp_pushes("w1010");
    bus(2'd2, 1'b1, 32'h4, 4'hf, rd, a);
    chk("irq_clr2", {31'd0, irq_o}, 32'd0);

    // Clear lands on the same edge as the word completion.
    bus(2'd0, 1'b1, 32'h0D0C0B0A, 4'hf, rd, a);
    idle(3);
    bus(2'd2, 1'b1, 32'h4, 4'hf, rd, a);
    chk("set_wins", {31'd0, irq_o}, 32'd1);
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("status_sw", rd, 32'h000A_0004);
    bus(2'd2, 1'b1, 32'h4, 4'hf, rd, a);
    chk("irq_clr3", {31'd0, irq_o}, 32'd0);
    pq_c.delete();
    pq_d.delete();

    // Back-pressure for 10 cycles starting at byte 1.
    bus(2'd0, 1'b1, 32'h44332211, 4'hf, rd, a);
    idle(1);
    fifo_full_i = 1'b1;
    bus(2'd2, 1'b0, 0, 0, rd, a2);
    chk("status_stall", rd, 32'h000B_0003);
    idle(9);
    fifo_full_i = 1'b0;
    exp_push(a, 'h11);
    exp_push(a + 11, 'h22);
    exp_push(a + 12, 'h33);
    exp_push(a + 13, 'h44);
    idle(5);
    cmp_pushes("stall");

    // Second DATA write issued while the first word is draining.
    bus(2'd0, 1'b1, 32'h04030201, 4'hf, rd, a);
    bus(2'd0, 1'b1, 32'h08070605, 4'hf, rd, a2);
    chk("b2b_ack_gap", a2 - a, 32'd5);
    for (int i = 0; i < 4; i++) exp_push(a + i, i + 1);
    for (int i = 0; i < 4; i++) exp_push(a2 + i, i + 5);
    idle(6);
    cmp_pushes("b2b");

    // Disable after two pushes aborts the rest of the word.
    bus(2'd2, 1'b1, 32'h4, 4'hf, rd, a2);
    bus(2'd0, 1'b1, 32'h44332211, 4'hf, rd, a);
    idle(1);
    bus(2'd1, 1'b1, 32'h2, 4'hf, rd, a2);
    exp_push(a, 'h11);
    exp_push(a + 1, 'h22);
    idle(6);
    cmp_pushes("abort");
    chk("abort_irq", {31'd0, irq_o}, 32'd0);
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("status_abort", rd, 32'h0018_0000);
    bus(2'd0, 1'b1, 32'hFFFFFFFF, 4'hf, rd, a);
    idle(6);
    cmp_pushes("dis_write");
    chk("dis_irq", {31'd0, irq_o}, 32'd0);

    // Counter wrap: 24 + 228 + 3 = 255, then one more.
    bus(2'd1, 1'b1, 32'h1, 4'hf, rd, a);
    for (int i = 0; i < 57; i++)
      bus(2'd0, 1'b1, 32'h01020304, 4'hf, rd, a);
    bus(2'd0, 1'b1, 32'h00030201, 4'b0111, rd, a);
    idle(6);
    chk("wrap_pushes", pq_d.size(), 32'd231);
    pq_c.delete();
    pq_d.delete();
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("status_255", rd, 32'h00FF_0004);
    bus(2'd0, 1'b1, 32'h000000AB, 4'b0001, rd, a);
    exp_push(a, 'hAB);
    idle(6);
    cmp_pushes("wrap1");
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("status_wrap", rd, 32'h0000_0004);

    // Reset in the middle of a word drops the remaining bytes.
    bus(2'd0, 1'b1, 32'h55443322, 4'hf, rd, a);
    idle(1);
    resetn = 1'b0;
    idle(1);
    chk("mid_rst_we", {31'd0, we_o}, 32'd0);
    chk("mid_rst_pcm", {24'd0, pcm_o}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
    idle(3);
    resetn = 1'b1;
    exp_push(a, 'h22);
    exp_push(a + 1, 'h33);
    idle(1);
    cmp_pushes("mid_rst");
    bus(2'd1, 1'b0, 0, 0, rd, a);
    chk("post_rst_ctrl", rd, 32'h0);
    bus(2'd2, 1'b0, 0, 0, rd, a);
    chk("post_rst_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
